bin_bbox_detect: RTL

- Sits directly downstream of the 3x3 binary erosion stage and consumes its vsync/hsync/valid/bit stream.
- Tracks the bounding box and the pixel count of foreground pixels (bit = 1) in each frame.
- Latches the result at end of frame and pulses a done strobe, for use by the target-tracking and overlay logic.
- Passes the video stream through with 1 cycle of latency.

---
 rtl/bin_bbox_detect.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/bin_bbox_detect.sv
// Purpose : bounding box and foreground pixel count of a binary video frame, with pass-through.
// Latency : video pass-through 1 clk; results latched on the clock after vsync falls (box_done pulse).
// Backpr. : none; the stream is consumed every cycle, results hold until the next frame end.
module bin_bbox_detect #(
   parameter int IMG_H_DISP = 640,
   parameter int IMG_V_DISP = 480,
   parameter int X_W        = 10,
   parameter int Y_W        = 10,
   parameter int CNT_W      = 19,
   parameter int MIN_PIXELS = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pre_frame_vsync,
   input  logic             pre_frame_hsync,
   input  logic             pre_frame_valid,
   input  logic             pre_img_bit,
   output logic             post_frame_vsync,
   output logic             post_frame_hsync,
   output logic             post_frame_valid,
   output logic             post_img_bit,
   output logic [X_W-1:0]   box_x_min,
   output logic [X_W-1:0]   box_x_max,
   output logic [Y_W-1:0]   box_y_min,
   output logic [Y_W-1:0]   box_y_max,
   output logic [CNT_W-1:0] box_pix_cnt,
   output logic             box_found,
   output logic             box_done
);

   // Limits widened by one bit so a display size equal to 2^X_W still compares correctly.
   localparam logic [X_W:0]     H_LIM   = (X_W+1)'(IMG_H_DISP);
   localparam logic [Y_W:0]     V_LIM   = (Y_W+1)'(IMG_V_DISP);
   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

   // Previous-sample sync registers and frame tracking flag.
   logic             vsync_d;
   logic             hsync_d;
   logic             in_frame;

   // Running per-frame state.
   logic [X_W-1:0]   x;
   logic [Y_W-1:0]   y;
   logic [CNT_W-1:0] cnt;
   logic [X_W-1:0]   xmin;
   logic [X_W-1:0]   xmax;
   logic [Y_W-1:0]   ymin;
   logic [Y_W-1:0]   ymax;

   // State as seen by the current cycle (start of frame re-initialises it).
   logic [X_W-1:0]   x_base;
   logic [Y_W-1:0]   y_base;
   logic [CNT_W-1:0] cnt_base;
   logic [X_W-1:0]   xmin_base;
   logic [X_W-1:0]   xmax_base;
   logic [Y_W-1:0]   ymin_base;
   logic [Y_W-1:0]   ymax_base;

   // Next running state.
   logic [X_W-1:0]   x_nxt;
   logic [Y_W-1:0]   y_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [X_W-1:0]   xmin_nxt;
   logic [X_W-1:0]   xmax_nxt;
   logic [Y_W-1:0]   ymin_nxt;
   logic [Y_W-1:0]   ymax_nxt;

   logic             vs_rise;
   logic             vs_fall;
   logic             hs_fall;
   logic             pix;
   logic             fg;

   assign vs_rise = pre_frame_vsync & ~vsync_d;
   // Only a frame that was seen starting can end; this drops a frame cut by reset.
   assign vs_fall = ~pre_frame_vsync & vsync_d & in_frame;
   assign hs_fall = ~pre_frame_hsync & hsync_d;

   // A start-of-frame cycle may itself carry a pixel at (0,0).
   assign pix = (in_frame | vs_rise) & pre_frame_vsync & pre_frame_hsync & pre_frame_valid;

   assign x_base    = vs_rise ? '0 : x;
   assign y_base    = vs_rise ? '0 : y;
   assign cnt_base  = vs_rise ? '0 : cnt;
   assign xmin_base = vs_rise ? '1 : xmin;
   assign xmax_base = vs_rise ? '0 : xmax;
   assign ymin_base = vs_rise ? '1 : ymin;
   assign ymax_base = vs_rise ? '0 : ymax;

   assign fg = pix & pre_img_bit
             & ({1'b0, x_base} < H_LIM)
             & ({1'b0, y_base} < V_LIM);

   // Next running state: pixel advance, foreground accumulation, end-of-line wrap.
   always_comb begin
      x_nxt    = x_base;
      y_nxt    = y_base;
      cnt_nxt  = cnt_base;
      xmin_nxt = xmin_base;
      xmax_nxt = xmax_base;
      ymin_nxt = ymin_base;
      ymax_nxt = ymax_base;

      if (pix && (x_base != '1)) begin
         x_nxt = x_base + X_W'(1);
      end

      if (fg) begin
         if (x_base < xmin_base) xmin_nxt = x_base;
         if (x_base > xmax_base) xmax_nxt = x_base;
         if (y_base < ymin_base) ymin_nxt = y_base;
         if (y_base > ymax_base) ymax_nxt = y_base;
         if (cnt_base != '1) cnt_nxt = cnt_base + CNT_W'(1);
      end

      // Start of frame takes priority over a coincident line end, keeping y at 0.
      if (hs_fall && in_frame && !vs_rise) begin
         x_nxt = '0;
         if (y_base != '1) y_nxt = y_base + Y_W'(1);
      end
   end

   // Sync edge history and frame-active flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_d  <= 1'b1;
         hsync_d  <= 1'b1;
         in_frame <= 1'b0;
      end else begin
         vsync_d <= pre_frame_vsync;
         hsync_d <= pre_frame_hsync;
         if (vs_rise) begin
            in_frame <= 1'b1;
         end else if (vs_fall) begin
            in_frame <= 1'b0;
         end
      end
   end

   // Running coordinate and extent registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x    <= '0;
         y    <= '0;
         cnt  <= '0;
         xmin <= '1;
         xmax <= '0;
         ymin <= '1;
         ymax <= '0;
      end else begin
         x    <= x_nxt;
         y    <= y_nxt;
         cnt  <= cnt_nxt;
         xmin <= xmin_nxt;
         xmax <= xmax_nxt;
         ymin <= ymin_nxt;
         ymax <= ymax_nxt;
      end
   end

   // End-of-frame latch of the result and one-cycle done strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         box_x_min   <= '0;
         box_x_max   <= '0;
         box_y_min   <= '0;
         box_y_max   <= '0;
         box_pix_cnt <= '0;
         box_found   <= 1'b0;
         box_done    <= 1'b0;
      end else begin
         box_done <= vs_fall;
         if (vs_fall) begin
            box_pix_cnt <= cnt;
            if (cnt >= MIN_CNT) begin
               box_found <= 1'b1;
               box_x_min <= xmin;
               box_x_max <= xmax;
               box_y_min <= ymin;
               box_y_max <= ymax;
            end else begin
               box_found <= 1'b0;
               box_x_min <= '0;
               box_x_max <= '0;
               box_y_min <= '0;
               box_y_max <= '0;
            end
         end
      end
   end

   // Video pass-through; the pixel bit is blanked outside the active line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         post_frame_vsync <= 1'b0;
         post_frame_hsync <= 1'b0;
         post_frame_valid <= 1'b0;
         post_img_bit     <= 1'b0;
      end else begin
         post_frame_vsync <= pre_frame_vsync;
         post_frame_hsync <= pre_frame_hsync;
         post_frame_valid <= pre_frame_valid;
         post_img_bit     <= pre_img_bit & pre_frame_hsync;
      end
   end

endmodule
